spi_shift_engine: RTL

Serial bit engine for the SPI peripheral. It sits directly downstream of the SPI master's bus/buffer/control logic. Each transfer it accepts one parallel word plus a frame configuration, generates SCK with the selected polarity, phase and divider, and shifts MOSI out MSB-first while sampling MISO. It returns the received word with a one-cycle completion pulse, which the controller uses to refill its buffers.

---
 rtl/spi_shift_engine_if.sv | 32 +++
 rtl/spi_shift_engine.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/spi_shift_engine_if.sv
// spi_shift_engine_if: bundles the controller-facing transfer handshake and the
// SPI pin signals of the shift engine.
//   start, tx_data, len, cpol, cpha, div : transfer request and frame config
//   busy, done, rx_data                  : transfer status and received word
//   mosi, sck, miso                      : serial pins
// Modports:
//   master - controller / bench side (drives the request and miso)
//   slave  - engine side (drives the pins and status)
interface spi_shift_engine_if;
  logic        start;
  logic [31:0] tx_data;
  logic [1:0]  len;
  logic        cpol;
  logic        cpha;
  logic [3:0]  div;
  logic        miso;
  logic        mosi;
  logic        sck;
  logic        busy;
  logic        done;
  logic [31:0] rx_data;

  modport master (
    output start, tx_data, len, cpol, cpha, div, miso,
    input  mosi, sck, busy, done, rx_data
  );

  modport slave (
    input  start, tx_data, len, cpol, cpha, div, miso,
    output mosi, sck, busy, done, rx_data
  );
endinterface

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: SPI serial bit engine. Accepts one word plus frame config per
// transfer, generates SCK (polarity/phase/divider), shifts MOSI out MSB-first,
// samples MISO, and returns the received word with a one-cycle done pulse.
// Ports:
//   clk - system clock, posedge
//   rst - synchronous active-low reset
//   bus - spi_shift_engine_if.slave (request/config in, pins and status out)
module spi_shift_engine (
  input logic               clk,
  input logic               rst,
  spi_shift_engine_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StShift, StTail} state_e;

  state_e      state_q, state_d;
  logic [15:0] hcnt_q, hcnt_d;
  logic [6:0]  ecnt_q, ecnt_d;
  logic [31:0] tx_sr_q, tx_sr_d;
  logic [31:0] rx_sr_q, rx_sr_d;
  logic [31:0] rx_data_q, rx_data_d;
  logic [1:0]  len_q, len_d;
  logic        cpol_q, cpol_d;
  logic        cpha_q, cpha_d;
  logic [3:0]  div_q, div_d;
  logic        sck_q, sck_d;
  logic        mosi_q, mosi_d;
  logic        done_q, done_d;

  logic [31:0] tx_aligned;
  logic [15:0] h_last;
  logic [6:0]  last_edge;
  logic        edge_fire;
  logic        leading;
  logic        is_last;
  logic        drive_edge;
  logic        sample_edge;

  // Frame bit N-1 moved to bit 31 so the shifter always emits from the top.
  assign tx_aligned  = bus.tx_data << {~bus.len, 3'b000};
  assign h_last      = (16'd1 << div_q) - 16'd1;
  assign last_edge   = {1'b0, len_q, 4'hf};   // 2N-1
  assign edge_fire   = (hcnt_q == h_last);
  // ecnt_q counts edges already produced, so the firing edge is ecnt_q+1.
  assign leading     = ~ecnt_q[0];
  assign is_last     = (ecnt_q == last_edge);
  // CPHA=0 holds the final bit across the last trailing edge.
  assign drive_edge  = cpha_q ? leading : (~leading & ~is_last);
  assign sample_edge = leading ^ cpha_q;

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    ecnt_d    = ecnt_q;
    tx_sr_d   = tx_sr_q;
    rx_sr_d   = rx_sr_q;
    rx_data_d = rx_data_q;
    len_d     = len_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    div_d     = div_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;

    case (state_q)
      StIdle: begin
        sck_d  = bus.cpol;
        mosi_d = 1'b0;
        if (bus.start) begin
          len_d   = bus.len;
          cpol_d  = bus.cpol;
          cpha_d  = bus.cpha;
          div_d   = bus.div;
          hcnt_d  = '0;
          ecnt_d  = '0;
          rx_sr_d = '0;
          state_d = StShift;
          if (bus.cpha) begin
            tx_sr_d = tx_aligned;
          end else begin
            mosi_d  = tx_aligned[31];
            tx_sr_d = {tx_aligned[30:0], 1'b0};
          end
        end
      end

      StShift: begin
        if (edge_fire) begin
          hcnt_d = '0;
          ecnt_d = ecnt_q + 7'd1;
          sck_d  = ~sck_q;
          if (drive_edge) begin
            mosi_d  = tx_sr_q[31];
            tx_sr_d = {tx_sr_q[30:0], 1'b0};
          end
          if (sample_edge) begin
            rx_sr_d = {rx_sr_q[30:0], bus.miso};
          end
          if (is_last) begin
            state_d = StTail;
          end
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end

      StTail: begin
        if (edge_fire) begin
          state_d   = StIdle;
          done_d    = 1'b1;
          rx_data_d = rx_sr_q;
          mosi_d    = 1'b0;
          hcnt_d    = '0;
        end else begin
          hcnt_d = hcnt_q + 16'd1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= StIdle;
      hcnt_q    <= '0;
      ecnt_q    <= '0;
      tx_sr_q   <= '0;
      rx_sr_q   <= '0;
      rx_data_q <= '0;
      len_q     <= '0;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      div_q     <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      ecnt_q    <= ecnt_d;
      tx_sr_q   <= tx_sr_d;
      rx_sr_q   <= rx_sr_d;
      rx_data_q <= rx_data_d;
      len_q     <= len_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      div_q     <= div_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  assign bus.sck     = sck_q;
  assign bus.mosi    = mosi_q;
  assign bus.busy    = (state_q != StIdle);
  assign bus.done    = done_q;
  assign bus.rx_data = rx_data_q;

endmodule
